network_lock_sequencer: RTL and testbench
=========================================

Name: network_lock_sequencer

Overview:
Sequences start-up and gain scheduling of the 2x2 ADPLL ring network (nodes 11, 12, 21, 22). Nodes are enabled in wavefront order: 11 first, then 12 and 21, then 22. Each stage waits for phase lock before the next node is enabled. After full lock the sequencer drops the loop filters from acquisition gains to tracking gains. It also detects loss of lock and acquisition timeout, and sits between the board switch logic and the NetworkRing enable_i, kp_i and ki_i inputs.

Parameters:
PDET_WIDTH, 5, width of each signed phase-detector error word
LOCK_THRESH, 2, max |error| counted as in-lock
UNLOCK_THRESH, 6, |error| above this counted as out-of-lock while tracking
LOCK_COUNT, 16, consecutive in-lock ref ticks required to advance
UNLOCK_COUNT, 4, consecutive out-of-lock ref ticks required to leave TRACK
TIMEOUT, 4096, ref ticks allowed per acquisition stage before FAULT
KP_ACQ, 4'd8, kp during acquisition
KI_ACQ, 4'd4, ki during acquisition
KP_TRK, 4'd2, kp during tracking
KI_TRK, 4'd1, ki during tracking

Ports:
fpga_clk_i  in  1  system clock (258 MHz domain)
reset_i  in  1  asynchronous, active-high reset
start_i  in  1  level; high = run sequence, low = return to IDLE
ref_tick_i  in  1  one-cycle strobe per reference edge; error inputs valid on this cycle
err_i  in  4*PDET_WIDTH  two's-complement errors, slice order [0]=11, [1]=12, [2]=21, [3]=22
enable_o  out  4  per-node enable, same bit order
kp_o  out  4  kp select to all nodes
ki_o  out  4  ki select to all nodes
locked_o  out  1  high only in TRACK
fault_o  out  1  high only in FAULT
state_o  out  3  current state encoding

Behaviour:
- Reset: state IDLE, counters 0. enable_o=0, kp_o=0, ki_o=0, locked_o=0, fault_o=0, state_o=0.
- All outputs are registered and decoded from the state register. They change on the clock edge that performs a transition, so they are visible 1 cycle after the deciding ref_tick_i.
- States, with encoding / enable_o / gains:
  - IDLE: 0 / 0000 / 0,0
  - ACQ_11: 1 / 0001 / ACQ
  - ACQ_EDGE: 2 / 0111 / ACQ
  - ACQ_22: 3 / 1111 / ACQ
  - TRACK: 4 / 1111 / TRK
  - RELOCK: 5 / 1111 / ACQ
  - FAULT: 6 / 0000 / 0,0
- |error| is computed at PDET_WIDTH+1 bits, so -16 gives 16, not overflow.
- Only nodes enabled in the current state are evaluated. Disabled slices are ignored.
- Lock evaluation happens only on cycles where ref_tick_i=1:
  - All evaluated |err| <= LOCK_THRESH: lock_cnt increments, saturating at LOCK_COUNT.
  - Otherwise: lock_cnt clears to 0.
- Advance: when a tick makes lock_cnt reach LOCK_COUNT, the state moves to the next one and lock_cnt and tmo_cnt clear.
  - ACQ_11 -> ACQ_EDGE -> ACQ_22 -> TRACK
  - RELOCK -> TRACK
- Timeout: tmo_cnt increments on every ref tick in the ACQ_* and RELOCK states. Reaching TIMEOUT moves the state to FAULT.
- If lock completion and timeout happen on the same tick, the advance wins.
- TRACK:
  - Any enabled node with |err| > UNLOCK_THRESH on a tick increments unl_cnt. A tick where all nodes are within the threshold clears it.
  - unl_cnt reaching UNLOCK_COUNT moves the state to RELOCK and clears all counters.
- IDLE -> ACQ_11 on the first cycle with start_i=1. ref_tick_i is not required for this transition.
- start_i=0 in any state forces IDLE on the next edge and clears all counters. This overrides every other transition.
- FAULT holds until start_i=0.
- Asynchronous reset mid-sequence returns immediately to the reset values.
- No sequencing action is taken on cycles where ref_tick_i=0, apart from the start_i handling above.

Test Plan:
- Reset asserted mid-ACQ_EDGE -> outputs drop to 0 asynchronously; state_o=0 before the next clock edge.
- start_i=1, all err=0, ticks every 8 clocks -> ACQ_11 for 16 ticks, then enable_o=0111, then 1111, then TRACK; kp_o/ki_o 8/4 change to 2/1 and locked_o=1 after tick 48.
- In ACQ_11, err[0]=+3 on tick 10, then 0 -> counter restarts; advance occurs on tick 26. err[0]=-16 never counts as in-lock.
- In ACQ_11, err[1]=+15 with node 12 disabled -> ignored; advance still occurs on tick 16.
- In TRACK, err[3]=+7 for 3 ticks, then 0, then +7 for 4 ticks -> RELOCK only after the 4th consecutive tick. Gains return to 8/4, locked_o=0, enable_o stays 1111.
- err[0]=+5 constantly -> FAULT after 4096 ticks with enable_o=0 and fault_o=1. start_i=0 -> IDLE next cycle. start_i=1 -> ACQ_11.

Source files
------------

// File: rtl/network_lock_sequencer.sv
// network_lock_sequencer: wavefront start-up, lock supervision and gain scheduling for the 2x2 ADPLL ring
module network_lock_sequencer #(
    parameter int         PDET_WIDTH    = 5,
    parameter int         LOCK_THRESH   = 2,
    parameter int         UNLOCK_THRESH = 6,
    parameter int         LOCK_COUNT    = 16,
    parameter int         UNLOCK_COUNT  = 4,
    parameter int         TIMEOUT       = 4096,
    parameter logic [3:0] KP_ACQ        = 4'd8,
    parameter logic [3:0] KI_ACQ        = 4'd4,
    parameter logic [3:0] KP_TRK        = 4'd2,
    parameter logic [3:0] KI_TRK        = 4'd1
) (
    input  logic                    fpga_clk_i,
    input  logic                    reset_i,
    input  logic                    start_i,
    input  logic                    ref_tick_i,
    input  logic [4*PDET_WIDTH-1:0] err_i,
    output logic [3:0]              enable_o,
    output logic [3:0]              kp_o,
    output logic [3:0]              ki_o,
    output logic                    locked_o,
    output logic                    fault_o,
    output logic [2:0]              state_o
);
    localparam int LW = $clog2(LOCK_COUNT + 1);
    localparam int TW = $clog2(TIMEOUT + 1);
    localparam int UW = $clog2(UNLOCK_COUNT + 1);
    localparam logic [PDET_WIDTH:0] LOCK_T = LOCK_THRESH[PDET_WIDTH:0];
    localparam logic [PDET_WIDTH:0] UNL_T  = UNLOCK_THRESH[PDET_WIDTH:0];
    localparam logic [LW-1:0] LOCK_MAX = LOCK_COUNT[LW-1:0];
    localparam logic [TW-1:0] TMO_MAX  = TIMEOUT[TW-1:0];
    localparam logic [UW-1:0] UNL_MAX  = UNLOCK_COUNT[UW-1:0];

    typedef enum logic [2:0] {
        IDLE     = 3'd0,
        ACQ_11   = 3'd1,
        ACQ_EDGE = 3'd2,
        ACQ_22   = 3'd3,
        TRACK    = 3'd4,
        RELOCK   = 3'd5,
        FAULT    = 3'd6
    } state_t;

    state_t          state_q, state_d;
    logic [LW-1:0]   lock_cnt_q, lock_cnt_d, lock_inc;
    logic [TW-1:0]   tmo_cnt_q, tmo_cnt_d, tmo_inc;
    logic [UW-1:0]   unl_cnt_q, unl_cnt_d, unl_inc;
    logic [3:0]      enable_q, enable_d, kp_q, kp_d, ki_q, ki_d;
    logic            locked_q, locked_d, fault_q, fault_d, acq;
    logic [3:0]      in_lock, out_lock;
    logic [PDET_WIDTH:0] ext [4];
    logic [PDET_WIDTH:0] mag [4];

    // Per-node magnitude one bit wider than the error so the most negative code cannot wrap;
    // nodes not enabled in the current state always look in-lock and never out-of-lock.
    always_comb begin
        for (int i = 0; i < 4; i++) begin
            ext[i] = {err_i[i*PDET_WIDTH+PDET_WIDTH-1], err_i[i*PDET_WIDTH +: PDET_WIDTH]};
            mag[i] = ext[i][PDET_WIDTH] ? -ext[i] : ext[i];
            in_lock[i] = !enable_q[i] || mag[i] <= LOCK_T;
            out_lock[i] = enable_q[i] && mag[i] > UNL_T;
        end
    end

    // Next state and counters; start_i low dominates, then tick-driven lock/unlock/timeout decisions.
    always_comb begin
        state_d = state_q;
        lock_cnt_d = lock_cnt_q;
        tmo_cnt_d = tmo_cnt_q;
        unl_cnt_d = unl_cnt_q;
        lock_inc = &in_lock ? (lock_cnt_q == LOCK_MAX ? LOCK_MAX : lock_cnt_q + 1'b1) : '0;
        tmo_inc = tmo_cnt_q + 1'b1;
        unl_inc = |out_lock ? unl_cnt_q + 1'b1 : '0;
        if (!start_i) begin
            state_d = IDLE;
            lock_cnt_d = '0;
            tmo_cnt_d = '0;
            unl_cnt_d = '0;
        end else if (state_q == IDLE) begin
            state_d = ACQ_11;
        end else if (ref_tick_i && state_q == TRACK) begin
            unl_cnt_d = unl_inc;
            if (unl_inc == UNL_MAX) begin
                state_d = RELOCK;
                lock_cnt_d = '0;
                tmo_cnt_d = '0;
                unl_cnt_d = '0;
            end
        end else if (ref_tick_i && state_q != FAULT) begin
            lock_cnt_d = lock_inc;
            tmo_cnt_d = tmo_inc;
            if (lock_inc == LOCK_MAX) begin
                state_d = state_q == ACQ_11 ? ACQ_EDGE : state_q == ACQ_EDGE ? ACQ_22 : TRACK;
                lock_cnt_d = '0;
                tmo_cnt_d = '0;
            end else if (tmo_inc == TMO_MAX) begin
                state_d = FAULT;
                lock_cnt_d = '0;
                tmo_cnt_d = '0;
            end
        end
    end

    // Output decode of the upcoming state so registered outputs change on the transition edge.
    always_comb begin
        acq = state_d inside {ACQ_11, ACQ_EDGE, ACQ_22, RELOCK};
        enable_d = state_d == ACQ_11 ? 4'b0001 :
                   state_d == ACQ_EDGE ? 4'b0111 :
                   state_d inside {ACQ_22, TRACK, RELOCK} ? 4'b1111 : 4'b0000;
        kp_d = acq ? KP_ACQ : state_d == TRACK ? KP_TRK : 4'd0;
        ki_d = acq ? KI_ACQ : state_d == TRACK ? KI_TRK : 4'd0;
        locked_d = state_d == TRACK;
        fault_d = state_d == FAULT;
    end

    // State, counters and registered outputs, cleared asynchronously.
    always_ff @(posedge fpga_clk_i or posedge reset_i) begin
        if (reset_i) begin
            state_q <= IDLE;
            lock_cnt_q <= '0;
            tmo_cnt_q <= '0;
            unl_cnt_q <= '0;
            enable_q <= '0;
            kp_q <= '0;
            ki_q <= '0;
            locked_q <= 1'b0;
            fault_q <= 1'b0;
        end else begin
            state_q <= state_d;
            lock_cnt_q <= lock_cnt_d;
            tmo_cnt_q <= tmo_cnt_d;
            unl_cnt_q <= unl_cnt_d;
            enable_q <= enable_d;
            kp_q <= kp_d;
            ki_q <= ki_d;
            locked_q <= locked_d;
            fault_q <= fault_d;
        end
    end

    assign enable_o = enable_q;
    assign kp_o = kp_q;
    assign ki_o = ki_q;
    assign locked_o = locked_q;
    assign fault_o = fault_q;
    assign state_o = state_q;
endmodule

// File: tb/tb_network_lock_sequencer.sv
// tb_network_lock_sequencer: directed and randomized checks against a tick-level reference model
module tb_network_lock_sequencer;
    localparam int PW = 5;

    logic            fpga_clk_i = 1'b0;
    logic            reset_i, start_i, ref_tick_i;
    logic [4*PW-1:0] err_i;
    logic [3:0]      enable_o, kp_o, ki_o;
    logic            locked_o, fault_o;
    logic [2:0]      state_o;

    int errs = 0;
    int checks = 0;
    int m_st, m_lock, m_tmo, m_unl;
    int en_tab [7] = '{0, 1, 7, 15, 15, 15, 0};

    network_lock_sequencer dut (
        .fpga_clk_i(fpga_clk_i),
        .reset_i(reset_i),
        .start_i(start_i),
        .ref_tick_i(ref_tick_i),
        .err_i(err_i),
        .enable_o(enable_o),
        .kp_o(kp_o),
        .ki_o(ki_o),
        .locked_o(locked_o),
        .fault_o(fault_o),
        .state_o(state_o)
    );

    always #5 fpga_clk_i = ~fpga_clk_i;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errs++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
        end
    endtask

    function automatic bit is_acq(input int st);
        return st == 1 || st == 2 || st == 3 || st == 5;
    endfunction

    task automatic m_reset();
        m_st = 0;
        m_lock = 0;
        m_tmo = 0;
        m_unl = 0;
    endtask

    // Reference: one call per clock, stage number plus plain integer counters.
    task automatic model_step(input logic s, input logic t, input logic [4*PW-1:0] e);
        int v, a;
        bit all_ok, any_bad;
        if (!s) begin
            m_reset();
        end else if (m_st == 0) begin
            m_st = 1;
        end else if (t && m_st != 6) begin
            all_ok = 1;
            any_bad = 0;
            for (int i = 0; i < 4; i++) begin
                if (en_tab[m_st][i]) begin
                    v = $signed(e[i*PW +: PW]);
                    a = v < 0 ? -v : v;
                    if (a > 2) all_ok = 0;
                    if (a > 6) any_bad = 1;
                end
            end
            if (m_st == 4) begin
                m_unl = any_bad ? m_unl + 1 : 0;
                if (m_unl >= 4) begin
                    m_reset();
                    m_st = 5;
                end
            end else begin
                m_lock = all_ok ? m_lock + 1 : 0;
                m_tmo++;
                if (m_lock >= 16) begin
                    m_st = (m_st == 3 || m_st == 5) ? 4 : m_st + 1;
                    m_lock = 0;
                    m_tmo = 0;
                end else if (m_tmo >= 4096) begin
                    m_st = 6;
                    m_lock = 0;
                    m_tmo = 0;
                end
            end
        end
    endtask

    task automatic compare_all();
        chk("state", state_o, m_st);
        chk("enable", enable_o, en_tab[m_st]);
        chk("kp", kp_o, is_acq(m_st) ? 8 : (m_st == 4 ? 2 : 0));
        chk("ki", ki_o, is_acq(m_st) ? 4 : (m_st == 4 ? 1 : 0));
        chk("locked", locked_o, m_st == 4);
        chk("fault", fault_o, m_st == 6);
    endtask

    function automatic logic [4*PW-1:0] rnd_err(input int mode);
        logic [4*PW-1:0] e;
        int v;
        for (int i = 0; i < 4; i++) begin
            v = mode == 0 ? int'($urandom_range(0, 4)) - 2 :
                mode == 1 ? int'($urandom_range(0, 16)) - 8 : int'($urandom_range(0, 31)) - 16;
            e[i*PW +: PW] = v[PW-1:0];
        end
        return e;
    endfunction

    task automatic cyc(input logic s, input logic t, input logic [4*PW-1:0] e);
        start_i = s;
        ref_tick_i = t;
        err_i = e;
        model_step(s, t, e);
        @(posedge fpga_clk_i);
        @(negedge fpga_clk_i);
        compare_all();
    endtask

    // n ticks spaced gap clocks apart; non-tick cycles carry junk errors that must be ignored
    task automatic ticks(input int n, input logic [4*PW-1:0] e, input int gap);
        for (int k = 0; k < n; k++) begin
            for (int g = 1; g < gap; g++) cyc(1'b1, 1'b0, rnd_err(2));
            cyc(1'b1, 1'b1, e);
        end
    endtask

    initial begin
        int mode;
        reset_i = 1'b1;
        start_i = 1'b0;
        ref_tick_i = 1'b0;
        err_i = '0;
        m_reset();
        @(negedge fpga_clk_i);
        @(negedge fpga_clk_i);
        compare_all();
        reset_i = 1'b0;
        cyc(1'b0, 1'b0, '0);
        cyc(1'b1, 1'b0, '0);
        chk("start_acq11", state_o, 1);
        ticks(9, 20'd15 << 5, 8);
        ticks(1, 20'd3, 8);
        ticks(15, '0, 8);
        chk("restart_hold", state_o, 1);
        ticks(1, '0, 8);
        chk("tick26_adv", state_o, 2);
        chk("tick26_en", enable_o, 4'b0111);
        ticks(5, '0, 8);
        ticks(1, 20'h10, 8);
        ticks(3, '0, 8);
        chk("neg16_hold", state_o, 2);
        @(negedge fpga_clk_i);
        #2 reset_i = 1'b1;
        #1;
        chk("arst_state", state_o, 0);
        chk("arst_en", enable_o, 0);
        chk("arst_kp", kp_o, 0);
        m_reset();
        @(negedge fpga_clk_i);
        compare_all();
        reset_i = 1'b0;
        cyc(1'b1, 1'b0, '0);
        ticks(16, '0, 8);
        chk("wave_edge", enable_o, 4'b0111);
        ticks(16, '0, 8);
        chk("wave_22", enable_o, 4'b1111);
        ticks(15, '0, 8);
        chk("pre_trk_kp", kp_o, 8);
        chk("pre_trk_lock", locked_o, 0);
        ticks(1, '0, 8);
        chk("trk_kp", kp_o, 2);
        chk("trk_ki", ki_o, 1);
        chk("trk_lock", locked_o, 1);
        ticks(3, 20'd7 << 15, 8);
        ticks(1, '0, 8);
        ticks(3, 20'd7 << 15, 8);
        chk("unl_hold", state_o, 4);
        ticks(1, 20'd7 << 15, 8);
        chk("relock_st", state_o, 5);
        chk("relock_kp", kp_o, 8);
        chk("relock_en", enable_o, 4'b1111);
        chk("relock_lock", locked_o, 0);
        ticks(16, '0, 4);
        chk("relock_trk", state_o, 4);
        cyc(1'b0, 1'b1, '0);
        chk("stop_idle", state_o, 0);
        cyc(1'b1, 1'b0, '0);
        ticks(4095, 20'd5, 2);
        chk("pre_tmo", state_o, 1);
        ticks(1, 20'd5, 2);
        chk("tmo_fault", fault_o, 1);
        chk("tmo_en", enable_o, 0);
        ticks(5, '0, 2);
        chk("fault_hold", state_o, 6);
        cyc(1'b0, 1'b0, '0);
        chk("fault_clr", state_o, 0);
        cyc(1'b1, 1'b0, '0);
        chk("fault_rst", state_o, 1);
        mode = 0;
        for (int c = 0; c < 4000; c++) begin
            if (c % 64 == 0) mode = $urandom_range(0, 9) < 6 ? 0 : int'($urandom_range(1, 2));
            cyc($urandom_range(0, 299) != 0, $urandom_range(0, 1) == 1, rnd_err(mode));
        end
        $display("Result: errors=%0d of %0d checks", errs, checks);
        $finish;
    end
endmodule
